de0_nano_system_pio_led_out: RTL

Avalon-MM slave output PIO driving the DE0-Nano LED bank.
- Complements the switch input PIO: the CPU writes the pattern, and this block drives it onto the pins.
- Adds atomic set and clear registers, plus a per-bit hardware blink engine driven by a programmable prescaler, so software never bit-bangs timing.
- Sits on the system interconnect next to the other PIOs; out_port goes to the top-level LED pins.

---
 rtl/de0_nano_system_pio_led_out.sv | 105 ++++++++++
 1 files changed

// File: rtl/de0_nano_system_pio_led_out.sv
// Avalon-MM output PIO for the DE0-Nano LED bank: data register with atomic
// set/clear, per-bit blink mask and a programmable half-period prescaler.
module de0_nano_system_pio_led_out #(
    parameter int                      WIDTH        = 8,
    parameter logic [WIDTH-1:0]        RESET_VALUE  = '0,
    parameter int                      PERIOD_WIDTH = 26,
    parameter logic [PERIOD_WIDTH-1:0] PERIOD_RESET = PERIOD_WIDTH'(24999999)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    typedef enum logic [2:0] {
        ADDR_DATA       = 3'd0,
        ADDR_BLINK_MASK = 3'd1,
        ADDR_PERIOD     = 3'd2,
        ADDR_STATUS     = 3'd3,
        ADDR_OUTSET     = 3'd4,
        ADDR_OUTCLEAR   = 3'd5
    } reg_addr_e;

    logic [WIDTH-1:0]        data;
    logic [WIDTH-1:0]        blink_mask;
    logic [PERIOD_WIDTH-1:0] period;
    logic [PERIOD_WIDTH-1:0] cnt;
    logic                    phase;

    logic                    wr;
    logic [WIDTH-1:0]        wr_bits;
    logic [WIDTH-1:0]        data_next;
    logic [WIDTH-1:0]        mask_next;
    logic                    period_wr;
    logic [31:0]             rd_mux;
    logic                    unused_wdata;

    assign wr           = chipselect & ~write_n;
    assign wr_bits      = writedata[WIDTH-1:0];
    assign unused_wdata = ^writedata;

    // NOTE: every output of this block gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        data_next = data;
        mask_next = blink_mask;
        period_wr = 1'b0;
        rd_mux    = '0;

        if (wr) begin
            case (address)
                ADDR_DATA:       data_next = wr_bits;
                ADDR_BLINK_MASK: mask_next = wr_bits;
                ADDR_PERIOD:     period_wr = 1'b1;
                ADDR_OUTSET:     data_next = data | wr_bits;
                ADDR_OUTCLEAR:   data_next = data & ~wr_bits;
                default: ;
            endcase
        end

        case (address)
            ADDR_DATA:       rd_mux[WIDTH-1:0]        = data;
            ADDR_BLINK_MASK: rd_mux[WIDTH-1:0]        = blink_mask;
            ADDR_PERIOD:     rd_mux[PERIOD_WIDTH-1:0] = period;
            ADDR_STATUS:     rd_mux[0]                = phase;
            default: ;
        endcase
    end

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values, e.g. out_port sees the old data and phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            data       <= RESET_VALUE;
            blink_mask <= '0;
            period     <= PERIOD_RESET;
            cnt        <= PERIOD_RESET;
            phase      <= 1'b0;
            out_port   <= RESET_VALUE;
            readdata   <= '0;
        end else begin
            data       <= data_next;
            blink_mask <= mask_next;
            readdata   <= rd_mux;
            out_port   <= data & ~(blink_mask & {WIDTH{phase}});

            // A PERIOD write restarts the half-period from the new value.
            if (period_wr) begin
                period <= writedata[PERIOD_WIDTH-1:0];
                cnt    <= writedata[PERIOD_WIDTH-1:0];
                phase  <= 1'b0;
            end else if (cnt == '0) begin
                cnt    <= period;
                phase  <= ~phase;
            end else begin
                cnt    <= cnt - PERIOD_WIDTH'(1);
            end
        end
    end

endmodule
